// File: rtl/shift_rotate_seq_if.sv
// Valid/ready bundle for the shift/rotate stage: operand request in, result and carry out.
// The stage side uses the slave modport; the requester/consumer side uses master.
interface shift_rotate_seq_if #(
    parameter int WIDTH = 20,
    parameter int AMT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;

    modport slave (
        input  in_valid, in_data, in_amt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );

    modport master (
        output in_valid, in_data, in_amt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );
endinterface

// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate stage: one single-bit rotate/shift step per clock.
// Result and last shifted-out bit are returned over a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for an operand, in_ready high
// RUN    | stepping one bit per cycle until count reaches 0
// DONE   | result presented, waiting for out_ready
module shift_rotate_seq #(
    parameter int WIDTH = 20,
    parameter int AMT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    shift_rotate_seq_if.slave   bus,
    output logic                busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_ROR = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [AMT_W-1:0] eff;

    // Amount never exceeds 2*WIDTH-1, so one conditional subtract gives the modulo.
    always_comb begin
        eff = bus.in_amt;
        if (!bus.in_op[1]) begin
            if (bus.in_amt >= W_AMT) eff = bus.in_amt - W_AMT;
        end else begin
            if (bus.in_amt > W_AMT) eff = W_AMT;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    op_d    = bus.in_op;
                    cnt_d   = eff;
                    carry_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - AMT_W'(1);
                    case (op_q)
                        OP_ROL: begin
                            data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                            carry_d = data_q[WIDTH-1];
                        end
                        OP_ROR: begin
                            data_d  = {data_q[0], data_q[WIDTH-1:1]};
                            carry_d = data_q[0];
                        end
                        OP_SHL: begin
                            data_d  = {data_q[WIDTH-2:0], 1'b0};
                            carry_d = data_q[WIDTH-1];
                        end
                        OP_SHR: begin
                            data_d  = {1'b0, data_q[WIDTH-1:1]};
                            carry_d = data_q[0];
                        end
                        default: ;
                    endcase
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = data_q;
    assign bus.out_carry = carry_q;
    assign busy          = (state_q == S_RUN) || (state_q == S_DONE);
endmodule
